// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx serializer among N_REQ requesters.
// Optional watchdog is compiled in when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [N_REQ-1:0]   Req,
  input  logic [8*N_REQ-1:0] Req_data,
  output logic [N_REQ-1:0]   Grant,
  output logic [N_REQ-1:0]   Ack,
  output logic               Busy,
  output logic               Tx_start,
  output logic [7:0]         Tx_data,
  input  logic               Tx_eot,
  output logic               Timeout_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE, START, WAIT_BUSY, WAIT_DONE, ACK
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] nxt_ptr;
  logic          found;
  logic [7:0]    pick_data;

  // first pending requester at or after ptr, wrapping
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && Req[IW'((int'(ptr) + k) % N_REQ)]) begin
        found    = 1'b1;
        pick_idx = IW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  // byte of the requester about to be granted
  always_comb begin
    pick_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (int'(pick_idx) == k) pick_data = Req_data[8*k +: 8];
    end
  end

  assign nxt_ptr  = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
  assign Tx_start = (state == START);
  assign Busy     = (state != IDLE) | Timeout_err;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        tmo_hit;

  assign tmo_hit = ((state == WAIT_BUSY) || (state == WAIT_DONE)) &&
                   (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

  // watchdog: cleared at launch, saturating count while waiting on the serializer
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wd_cnt      <= '0;
      Timeout_err <= 1'b0;
    end else begin
      Timeout_err <= tmo_hit;
      if (state == START) begin
        wd_cnt <= '0;
      end else if ((state == WAIT_BUSY) || (state == WAIT_DONE)) begin
        if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
`else
  assign Timeout_err = 1'b0;
`endif

  // arbitration and transfer tracking FSM
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      Grant   <= '0;
      Ack     <= '0;
      Tx_data <= '0;
      ptr     <= '0;
      win_idx <= '0;
    end else begin
      Ack <= '0;
      unique case (state)
        IDLE: begin
          if (found && Tx_eot) begin
            Grant   <= N_REQ'(1) << pick_idx;
            Tx_data <= pick_data;
            win_idx <= pick_idx;
            state   <= START;
          end
        end
        START: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (!Tx_eot) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (Tx_eot) begin
            Ack   <= Grant;
            state <= ACK;
          end
        end
        ACK: begin
          ptr   <= nxt_ptr;
          Grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
      if (tmo_hit) begin
        Ack   <= '0;
        ptr   <= nxt_ptr;
        Grant <= '0;
        state <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a small uart_tx model.
// Expected grants, bytes, frames, acks and watchdog delays are queued by the stimulus.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;
  localparam int BIT = 3;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [N-1:0] Req;
  logic [8*N-1:0] Req_data;
  logic [N-1:0] Grant;
  logic [N-1:0] Ack;
  logic         Busy;
  logic         Tx_start;
  logic [7:0]   Tx_data;
  logic         Tx_eot;
  logic         Timeout_err;

  logic force_low;
  logic tie_one;
  logic eot_m = 1'b1;
  logic m_busy = 1'b0;
  int   m_cnt = 0;
  logic [9:0] frame = '0;
  logic frame_done = 1'b0;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int start_cnt = 0;
  int tmo_cnt = 0;
  int last_start = 0;

  typedef struct {
    logic [N-1:0] g;
    logic [7:0]   d;
  } st_t;

  st_t          exp_start_q[$];
  logic [N-1:0] exp_ack_q[$];
  logic [9:0]   exp_frame_q[$];
  int           exp_tmo_q[$];

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Req_data(Req_data),
    .Grant(Grant), .Ack(Ack), .Busy(Busy), .Tx_start(Tx_start),
    .Tx_data(Tx_data), .Tx_eot(Tx_eot), .Timeout_err(Timeout_err)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  assign Tx_eot = force_low ? 1'b0 : (tie_one ? 1'b1 : eot_m);

  function automatic logic bitval(int k, logic [7:0] d);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[k-1];
  endfunction

  // uart_tx model: reads Tx_data live at each bit centre
  always @(posedge Clk) begin
    frame_done <= 1'b0;
    if (Rst) begin
      m_busy <= 1'b0;
      eot_m  <= 1'b1;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (Tx_start && !tie_one) begin
        m_busy <= 1'b1;
        eot_m  <= 1'b0;
        m_cnt  <= 0;
      end
    end else begin
      if (m_cnt % BIT == BIT / 2)
        frame[m_cnt/BIT] <= bitval(m_cnt / BIT, Tx_data);
      if (m_cnt == 10 * BIT - 1) begin
        m_busy     <= 1'b0;
        eot_m      <= 1'b1;
        frame_done <= 1'b1;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic bad(string nm);
    total++;
    $display("FAIL %s: unexpected event or expired wait (t=%0t)", nm, $time);
  endtask

  // monitor: pop and compare whenever the DUT presents an output event
  always @(negedge Clk) begin
    if (Tx_start === 1'b1) begin
      start_cnt++;
      last_start = cyc;
      if (exp_start_q.size() == 0) bad("unexp_start");
      else begin
        st_t e;
        e = exp_start_q.pop_front();
        chk("start_grant", 32'(Grant), 32'(e.g));
        chk("start_data", 32'(Tx_data), 32'(e.d));
      end
    end
    if (|Ack === 1'b1) begin
      ack_cnt++;
      if (exp_ack_q.size() == 0) bad("unexp_ack");
      else chk("ack", 32'(Ack), 32'(exp_ack_q.pop_front()));
    end
    if (frame_done) begin
      if (exp_frame_q.size() == 0) bad("unexp_frame");
      else chk("frame", 32'(frame), 32'(exp_frame_q.pop_front()));
    end
    if (Timeout_err === 1'b1) begin
      tmo_cnt++;
      if (exp_tmo_q.size() == 0) bad("unexp_timeout");
      else chk("tmo_delay", 32'(cyc - last_start), 32'(exp_tmo_q.pop_front()));
    end
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic push_xfer(logic [N-1:0] g, logic [7:0] d, bit full);
    st_t e;
    e.g = g;
    e.d = d;
    exp_start_q.push_back(e);
    if (full) begin
      exp_frame_q.push_back({1'b1, d, 1'b0});
      exp_ack_q.push_back(g);
    end
  endtask

  task automatic wait_acks(int target, string nm);
    int n;
    n = 0;
    while (ack_cnt < target && n < 400) begin
      tick();
      n++;
    end
    if (ack_cnt < target) bad(nm);
  endtask

  task automatic wait_grant(logic [N-1:0] g, string nm);
    int n;
    n = 0;
    while (Grant !== g && n < 400) begin
      tick();
      n++;
    end
    if (Grant !== g) bad(nm);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int blk;
    Rst = 1'b1;
    Req = '0;
    Req_data = '0;
    force_low = 1'b0;
    tie_one = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(Grant), 0);
    chk("rst_ack", 32'(Ack), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_start", 32'(Tx_start), 0);
    chk("rst_data", 32'(Tx_data), 0);
    chk("rst_tmo", 32'(Timeout_err), 0);
    Rst = 1'b0;
    tick();

    // T1 single requester
    Req_data[7:0] = 8'h55;
    push_xfer(4'b0001, 8'h55, 1'b1);
    Req = 4'b0001;
    tick();
    chk("t1_grant_lat", 32'(Grant), 32'h1);
    chk("t1_start_lat", 32'(Tx_start), 1);
    chk("t1_busy", 32'(Busy), 1);
    wait_acks(1, "t1_ack_wait");
    Req = '0;
    tick();

    // T2 fairness with all requesting
    do_reset();
    for (int i = 0; i < N; i++) Req_data[8*i +: 8] = 8'hA0 + 8'(i);
    for (int i = 0; i < 5; i++)
      push_xfer(4'(1 << (i % N)), 8'hA0 + 8'(i % N), 1'b1);
    Req = 4'b1111;
    wait_acks(ack_cnt + 5, "t2_ack_wait");
    Req = '0;
    tick();

    // T3 skip idle requesters, drop Req[1] and change its data mid-transfer
    do_reset();
    Req_data = '0;
    Req_data[15:8]  = 8'hB1;
    Req_data[31:24] = 8'hB3;
    push_xfer(4'b0010, 8'hB1, 1'b1);
    push_xfer(4'b1000, 8'hB3, 1'b1);
    push_xfer(4'b0010, 8'hB1, 1'b1);
    push_xfer(4'b1000, 8'hB3, 1'b1);
    blk = ack_cnt;
    Req = 4'b1010;
    wait_acks(blk + 2, "t3_ack2_wait");
    wait_grant(4'b0010, "t3_regrant");
    Req = 4'b1000;
    Req_data[15:8] = 8'hEE;
    wait_acks(blk + 4, "t3_ack4_wait");
    Req = '0;
    tick();

    // T4 serializer busy blocks granting
    force_low = 1'b1;
    Req_data[23:16] = 8'hC2;
    Req = 4'b0100;
    blk = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (Grant !== 4'b0000 || Tx_start !== 1'b0 || Busy !== 1'b0) blk++;
    end
    chk("t4_blocked", 32'(blk), 0);
    push_xfer(4'b0100, 8'hC2, 1'b1);
    force_low = 1'b0;
    tick();
    chk("t4_grant", 32'(Grant), 32'h4);
    wait_acks(ack_cnt + 1, "t4_ack_wait");
    Req = '0;
    tick();

    // T5 reset during WAIT_DONE; ptr (now 3) must return to 0
    Req_data[31:24] = 8'h5A;
    Req_data[7:0]   = 8'h30;
    push_xfer(4'b1000, 8'h5A, 1'b0);
    Req = 4'b1000;
    wait_grant(4'b1000, "t5_grant3");
    repeat (6) tick();
    chk("t5_in_wait", 32'(Tx_eot), 0);
    blk = ack_cnt;
    Rst = 1'b1;
    tick();
    chk("t5_grant", 32'(Grant), 0);
    chk("t5_busy", 32'(Busy), 0);
    chk("t5_start", 32'(Tx_start), 0);
    chk("t5_data", 32'(Tx_data), 0);
    Rst = 1'b0;
    push_xfer(4'b0001, 8'h30, 1'b1);
    Req = 4'b1001;
    tick();
    chk("t5_ptr_reset", 32'(Grant), 32'h1);
    wait_acks(blk + 1, "t5_ack_wait");
    chk("t5_no_abort_ack", 32'(ack_cnt), 32'(blk + 1));
    Req = '0;
    tick();

    // T6 watchdog
    do_reset();
    tie_one = 1'b1;
    Req_data[7:0]  = 8'h11;
    Req_data[15:8] = 8'h22;
`ifdef UART_TX_ARB_TIMEOUT_EN
    push_xfer(4'b0001, 8'h11, 1'b0);
    exp_tmo_q.push_back(TMO + 1);
    push_xfer(4'b0010, 8'h22, 1'b0);
    exp_tmo_q.push_back(TMO + 1);
    blk = start_cnt;
    Req = 4'b0011;
    for (int n = 0; n < 200 && start_cnt < blk + 2; n++) tick();
    Req = '0;
    for (int n = 0; n < 200 && tmo_cnt < 2; n++) tick();
    chk("t6_tmo_count", 32'(tmo_cnt), 2);
    chk("t6_grant_idle", 32'(Grant), 0);
`else
    push_xfer(4'b0001, 8'h11, 1'b0);
    Req = 4'b0001;
    repeat (40) tick();
    chk("t6_stuck_busy", 32'(Busy), 1);
    chk("t6_stuck_grant", 32'(Grant), 32'h1);
    chk("t6_tmo_zero", 32'(tmo_cnt), 0);
    Req = '0;
`endif
    do_reset();
    tie_one = 1'b0;
    repeat (3) tick();

    chk("left_start", 32'(exp_start_q.size()), 0);
    chk("left_ack", 32'(exp_ack_q.size()), 0);
    chk("left_frame", 32'(exp_frame_q.size()), 0);
    chk("left_tmo", 32'(exp_tmo_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
